// File: rtl/ififo_simple.sv
// Instruction FIFO between fetch and dispatch: DEPTH-entry circular buffer with
// wrap-bit pointers, valid/ready on both sides and a single-cycle flush on redirect.
package ififo_simple_pkg;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic               is_cond_br;
    logic               br_dir_pred;
    logic [ADDR_W-1:0]  br_target_pred;
  } ififo_entry_t;
endpackage

module ififo_simple
  import ififo_simple_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_aL,
  input  logic                 fetch_ififo_valid,
  output logic                 fetch_ififo_ready,
  input  ififo_entry_t         fetch_ififo_data,
  output logic                 ififo_dispatch_valid,
  input  logic                 ififo_dispatch_ready,
  output ififo_entry_t         ififo_dispatch_data,
  input  logic                 fetch_redirect_valid,
  output logic [PTR_WIDTH:0]   ififo_count
);

  localparam int unsigned PTR_W = PTR_WIDTH + 1;

  ififo_entry_t           mem [DEPTH];
  logic [PTR_W-1:0]       head;
  logic [PTR_W-1:0]       tail;
  logic                   empty;
  logic                   full;
  logic                   enq;
  logic                   deq;

  // Status and handshake decode; ready never looks at the dispatch side.
  always_comb begin
    empty                = (head == tail);
    full                 = (head[PTR_WIDTH-1:0] == tail[PTR_WIDTH-1:0]) &&
                           (head[PTR_WIDTH] != tail[PTR_WIDTH]);
    fetch_ififo_ready    = !full;
    ififo_dispatch_valid = !empty;
    enq                  = fetch_ififo_valid && !full;
    deq                  = !empty && ififo_dispatch_ready;
    ififo_count          = tail - head;
    ififo_dispatch_data  = mem[head[PTR_WIDTH-1:0]];
  end

  // Pointer update: reset beats flush, flush beats enq/deq.
  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      head <= '0;
      tail <= '0;
    end else if (fetch_redirect_valid) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (enq) tail <= tail + PTR_W'(1);
      if (deq) head <= head + PTR_W'(1);
    end
  end

  // Storage is not reset; entries are only observable through the valid range.
  always_ff @(posedge clk) begin
    if (rst_aL && !fetch_redirect_valid && enq) begin
      mem[tail[PTR_WIDTH-1:0]] <= fetch_ififo_data;
    end
  end

endmodule

// File: tb/tb_ififo_simple.sv
// Directed bench for ififo_simple: fill/full, drain order, wrap under streaming,
// flush, enqueue latency/hold, and mid-operation reset.
module tb_ififo_simple;
  import ififo_simple_pkg::*;

  logic         clk = 1'b0;
  logic         rst_aL;
  logic         fetch_ififo_valid;
  logic         fetch_ififo_ready;
  ififo_entry_t fetch_ififo_data;
  logic         ififo_dispatch_valid;
  logic         ififo_dispatch_ready;
  ififo_entry_t ififo_dispatch_data;
  logic         fetch_redirect_valid;
  logic [3:0]   ififo_count;

  int n_cmp = 0;
  int n_bad = 0;

  ififo_simple #(.DEPTH(8)) dut (
    .clk                  (clk),
    .rst_aL               (rst_aL),
    .fetch_ififo_valid    (fetch_ififo_valid),
    .fetch_ififo_ready    (fetch_ififo_ready),
    .fetch_ififo_data     (fetch_ififo_data),
    .ififo_dispatch_valid (ififo_dispatch_valid),
    .ififo_dispatch_ready (ififo_dispatch_ready),
    .ififo_dispatch_data  (ififo_dispatch_data),
    .fetch_redirect_valid (fetch_redirect_valid),
    .ififo_count          (ififo_count)
  );

  always #5 clk = ~clk;

  function automatic ififo_entry_t mk(input logic [31:0] pc);
    ififo_entry_t e;
    e.instr          = {16'hA5C3, pc[15:0]};
    e.pc             = pc;
    e.is_cond_br     = pc[2];
    e.br_dir_pred    = pc[3];
    e.br_target_pred = pc + 32'h0000_1000;
    return e;
  endfunction

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    fetch_ififo_valid = 1'b1;
    fetch_ififo_data  = mk(pc);
    step();
    fetch_ififo_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_aL = 1'b0;
    fetch_ififo_valid = 1'b0;
    fetch_ififo_data = mk(32'h0);
    ififo_dispatch_ready = 1'b0;
    fetch_redirect_valid = 1'b0;
    step(); step();
    rst_aL = 1'b1;
    n_cmp++; if (ififo_dispatch_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", ififo_dispatch_valid); end
    n_cmp++; if (fetch_ififo_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", fetch_ififo_ready); end
    n_cmp++; if (ififo_count !== 4'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", ififo_count); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      push(32'h100 + 32'(4 * i));
      n_cmp++; if (ififo_count !== 4'(i + 1)) begin n_bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, ififo_count, i + 1); end
    end
    n_cmp++; if (fetch_ififo_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got=%b exp=0", fetch_ififo_ready); end
    push(32'h120);
    n_cmp++; if (ififo_count !== 4'd8) begin n_bad++; $display("FAIL ninth_push_count got=%0d exp=8", ififo_count); end
    n_cmp++; if (ififo_dispatch_data !== mk(32'h100)) begin n_bad++; $display("FAIL full_head got=%h exp=%h", ififo_dispatch_data.pc, 32'h100); end
  endtask

  task automatic test_drain();
    ififo_dispatch_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (ififo_dispatch_valid !== 1'b1) begin n_bad++; $display("FAIL drain_valid[%0d] got=%b exp=1", i, ififo_dispatch_valid); end
      n_cmp++; if (ififo_dispatch_data !== mk(32'h100 + 32'(4 * i))) begin n_bad++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, ififo_dispatch_data.pc, 32'h100 + 32'(4 * i)); end
      step();
    end
    ififo_dispatch_ready = 1'b0;
    n_cmp++; if (ififo_dispatch_valid !== 1'b0) begin n_bad++; $display("FAIL drain_end_valid got=%b exp=0", ififo_dispatch_valid); end
    n_cmp++; if (ififo_count !== 4'd0) begin n_bad++; $display("FAIL drain_end_count got=%0d exp=0", ififo_count); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) push(32'h400 + 32'(4 * k));
    n_cmp++; if (ififo_count !== 4'd3) begin n_bad++; $display("FAIL b2b_start_count got=%0d exp=3", ififo_count); end
    ififo_dispatch_ready = 1'b1;
    fetch_ififo_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      fetch_ififo_data = mk(32'h400 + 32'(4 * (i + 3)));
      n_cmp++; if (ififo_dispatch_data !== mk(32'h400 + 32'(4 * i))) begin n_bad++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, ififo_dispatch_data.pc, 32'h400 + 32'(4 * i)); end
      step();
      n_cmp++; if (ififo_count !== 4'd3) begin n_bad++; $display("FAIL b2b_count[%0d] got=%0d exp=3", i, ififo_count); end
    end
    fetch_ififo_valid = 1'b0;
    for (int i = 20; i < 23; i++) begin
      n_cmp++; if (ififo_dispatch_data !== mk(32'h400 + 32'(4 * i))) begin n_bad++; $display("FAIL b2b_tail[%0d] got=%h exp=%h", i, ififo_dispatch_data.pc, 32'h400 + 32'(4 * i)); end
      step();
    end
    ififo_dispatch_ready = 1'b0;
    n_cmp++; if (ififo_dispatch_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_end_valid got=%b exp=0", ififo_dispatch_valid); end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 5; k++) push(32'h500 + 32'(4 * k));
    n_cmp++; if (ififo_count !== 4'd5) begin n_bad++; $display("FAIL flush_pre_count got=%0d exp=5", ififo_count); end
    fetch_redirect_valid = 1'b1;
    fetch_ififo_valid = 1'b1;
    fetch_ififo_data = mk(32'h5FC);
    ififo_dispatch_ready = 1'b1;
    step();
    fetch_redirect_valid = 1'b0;
    fetch_ififo_valid = 1'b0;
    ififo_dispatch_ready = 1'b0;
    n_cmp++; if (ififo_count !== 4'd0) begin n_bad++; $display("FAIL flush_count got=%0d exp=0", ififo_count); end
    n_cmp++; if (ififo_dispatch_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got=%b exp=0", ififo_dispatch_valid); end
    step();
    n_cmp++; if (ififo_dispatch_valid !== 1'b0) begin n_bad++; $display("FAIL flush_hold_valid got=%b exp=0", ififo_dispatch_valid); end
    push(32'h600);
    n_cmp++; if (ififo_dispatch_data !== mk(32'h600)) begin n_bad++; $display("FAIL flush_new_data got=%h exp=%h", ififo_dispatch_data.pc, 32'h600); end
    ififo_dispatch_ready = 1'b1;
    step();
    ififo_dispatch_ready = 1'b0;
    n_cmp++; if (ififo_dispatch_valid !== 1'b0) begin n_bad++; $display("FAIL flush_after_pop_valid got=%b exp=0", ififo_dispatch_valid); end
  endtask

  task automatic test_latency();
    fetch_ififo_valid = 1'b1;
    fetch_ififo_data = mk(32'h200);
    #1;
    n_cmp++; if (ififo_dispatch_valid !== 1'b0) begin n_bad++; $display("FAIL lat_same_cycle_valid got=%b exp=0", ififo_dispatch_valid); end
    step();
    fetch_ififo_valid = 1'b0;
    fetch_ififo_data = mk(32'hDEAD);
    n_cmp++; if (ififo_dispatch_valid !== 1'b1) begin n_bad++; $display("FAIL lat_valid got=%b exp=1", ififo_dispatch_valid); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (ififo_dispatch_data !== mk(32'h200)) begin n_bad++; $display("FAIL lat_hold[%0d] got=%h exp=%h", i, ififo_dispatch_data.pc, 32'h200); end
      n_cmp++; if (ififo_count !== 4'd1) begin n_bad++; $display("FAIL lat_hold_count[%0d] got=%0d exp=1", i, ififo_count); end
    end
    ififo_dispatch_ready = 1'b1;
    step();
    ififo_dispatch_ready = 1'b0;
    n_cmp++; if (ififo_dispatch_valid !== 1'b0) begin n_bad++; $display("FAIL lat_pop_valid got=%b exp=0", ififo_dispatch_valid); end
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 4; k++) push(32'h700 + 32'(4 * k));
    n_cmp++; if (ififo_count !== 4'd4) begin n_bad++; $display("FAIL mrst_pre_count got=%0d exp=4", ififo_count); end
    rst_aL = 1'b0;
    fetch_ififo_valid = 1'b1;
    fetch_ififo_data = mk(32'h7F0);
    ififo_dispatch_ready = 1'b1;
    step();
    rst_aL = 1'b1;
    fetch_ififo_valid = 1'b0;
    ififo_dispatch_ready = 1'b0;
    n_cmp++; if (ififo_count !== 4'd0) begin n_bad++; $display("FAIL mrst_count got=%0d exp=0", ififo_count); end
    n_cmp++; if (ififo_dispatch_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_valid got=%b exp=0", ififo_dispatch_valid); end
    n_cmp++; if (fetch_ififo_ready !== 1'b1) begin n_bad++; $display("FAIL mrst_ready got=%b exp=1", fetch_ififo_ready); end
    push(32'h300);
    n_cmp++; if (ififo_dispatch_valid !== 1'b1) begin n_bad++; $display("FAIL mrst_push_valid got=%b exp=1", ififo_dispatch_valid); end
    n_cmp++; if (ififo_dispatch_data !== mk(32'h300)) begin n_bad++; $display("FAIL mrst_push_data got=%h exp=%h", ififo_dispatch_data.pc, 32'h300); end
    ififo_dispatch_ready = 1'b1;
    step();
    ififo_dispatch_ready = 1'b0;
    n_cmp++; if (ififo_count !== 4'd0) begin n_bad++; $display("FAIL mrst_pop_count got=%0d exp=0", ififo_count); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_flush();
    test_latency();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
